// File: rtl/plot_framebuffer_sink.sv
// Receives pixel plots into a small FIFO, drains them into an on-chip framebuffer,
// and streams the stored frame out in raster order, one pixel every PIX_DIV clocks.
module plot_framebuffer_sink #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 4,
    parameter int PIX_DIV    = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [2:0] color,
    input  logic       plotPixel,
    output logic [7:0] pix_x,
    output logic [7:0] pix_y,
    output logic [2:0] pix_color,
    output logic       pix_valid,
    output logic       frame_start,
    output logic       clearing,
    output logic       overflow,
    output logic [2:0] fifo_level
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int AW     = 15;
    localparam int MEM_AW = $clog2(NPIX);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int DIV_W  = $clog2(PIX_DIV);

    localparam logic [AW-1:0]    LAST_ADDR = AW'(NPIX - 1);
    localparam logic [7:0]       X_LAST    = 8'(WIDTH - 1);
    localparam logic [7:0]       Y_LAST    = 8'(HEIGHT - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PIX_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [2:0]    color;
    } plot_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       clr_q, clr_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [7:0]          scan_x_q, scan_x_d;
    logic [7:0]          scan_y_q, scan_y_d;
    logic [AW-1:0]       scan_addr_q, scan_addr_d;
    plot_t               fifo_q [FIFO_DEPTH];
    plot_t               fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [PTR_W-1:0]    rptr_q, rptr_d;
    logic [LVL_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [7:0]          pix_x_q, pix_x_d;
    logic [7:0]          pix_y_q, pix_y_d;
    logic                pix_valid_q, pix_valid_d;
    logic                frame_start_q, frame_start_d;
    logic [2:0]          rd_data_q;

    logic                in_range, qual, full, empty, run, scan_slot, push, pop;
    logic [AW-1:0]       in_addr;
    plot_t               head;
    logic                mem_we, mem_re;
    logic [AW-1:0]       mem_addr;
    logic [2:0]          mem_wdata;

    logic [2:0]          mem [NPIX];

    // Request qualification and FIFO handshake; a pop in the same cycle frees a full FIFO.
    always_comb begin
        in_range  = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
        qual      = plotPixel && in_range;
        in_addr   = AW'(int'(y) * WIDTH + int'(x));
        full      = (count_q == LVL_FULL);
        empty     = (count_q == '0);
        run       = (state_q == S_RUN);
        scan_slot = run && (div_q == '0);
        pop       = run && (div_q != '0) && !empty;
        push      = qual && (!full || pop);
        head      = fifo_q[rptr_q];
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_CLEAR;
        else         state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLEAR: if (clr_q == LAST_ADDR) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_CLEAR;
        endcase
    end

    // FSM: outputs -- the single memory port is shared by clear, scan reads and drains
    always_comb begin
        clearing  = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = scan_addr_q;
        mem_wdata = 3'd0;
        case (state_q)
            S_CLEAR: begin
                clearing = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_q;
            end
            S_RUN: begin
                if (scan_slot) begin
                    mem_re   = 1'b1;
                    mem_addr = scan_addr_q;
                end else if (pop) begin
                    mem_we    = 1'b1;
                    mem_addr  = head.addr;
                    mem_wdata = head.color;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        clr_d         = clearing ? clr_q + AW'(1) : '0;
        div_d         = '0;
        scan_x_d      = scan_x_q;
        scan_y_d      = scan_y_q;
        scan_addr_d   = scan_addr_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_valid_d   = scan_slot;
        frame_start_d = scan_slot && (scan_x_q == '0) && (scan_y_q == '0);

        if (run) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

        if (scan_slot) begin
            pix_x_d = scan_x_q;
            pix_y_d = scan_y_q;
            if (scan_x_q == X_LAST) begin
                scan_x_d = '0;
                scan_y_d = (scan_y_q == Y_LAST) ? '0 : scan_y_q + 8'd1;
            end else begin
                scan_x_d = scan_x_q + 8'd1;
            end
            scan_addr_d = (scan_addr_q == LAST_ADDR) ? '0 : scan_addr_q + AW'(1);
        end
    end

    always_comb begin
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (qual && !push);
        if (push) begin
            fifo_d[wptr_q] = '{addr: in_addr, color: color};
            wptr_d         = wptr_q + PTR_W'(1);
        end
        if (pop) rptr_d = rptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + LVL_W'(1);
        else if (pop && !push) count_d = count_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clr_q         <= '0;
            div_q         <= '0;
            scan_x_q      <= '0;
            scan_y_q      <= '0;
            scan_addr_q   <= '0;
            fifo_q        <= '{default: '0};
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            clr_q         <= clr_d;
            div_q         <= div_d;
            scan_x_q      <= scan_x_d;
            scan_y_q      <= scan_y_d;
            scan_addr_q   <= scan_addr_d;
            fifo_q        <= fifo_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_valid_q   <= pix_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Framebuffer array is left unreset so it maps onto block RAM; CLEAR zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr[MEM_AW-1:0]] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (!resetn)     rd_data_q <= '0;
        else if (mem_re) rd_data_q <= mem[mem_addr[MEM_AW-1:0]];
    end

    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign pix_color   = rd_data_q;
    assign pix_valid   = pix_valid_q;
    assign frame_start = frame_start_q;
    assign overflow    = overflow_q;
    assign fifo_level  = 3'(count_q);

endmodule

// File: tb/tb_plot_framebuffer_sink.sv
// Directed + random bench for plot_framebuffer_sink using a reduced frame size
// and a plain-array picture of what the screen should show.
module tb_plot_framebuffer_sink;

    localparam int W  = 20;
    localparam int H  = 12;
    localparam int N  = W * H;
    localparam int PD = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic [2:0] color = '0;
    logic       plotPixel = 1'b0;
    logic [7:0] pix_x, pix_y;
    logic [2:0] pix_color;
    logic       pix_valid, frame_start, clearing, overflow;
    logic [2:0] fifo_level;

    plot_framebuffer_sink #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(4), .PIX_DIV(PD)) dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .color(color), .plotPixel(plotPixel),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_valid(pix_valid),
        .frame_start(frame_start), .clearing(clearing), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] fb [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_plot(input int px, input int py, input logic [2:0] c, input bit upd);
        x = 8'(px); y = 8'(py); color = c; plotPixel = 1'b1;
        if (upd && px < W && py < H) fb[py * W + px] = c;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0; plotPixel = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) fb[i] = 3'd0;
        chk("rst clearing", clearing, 1);
        chk("rst pix_valid", pix_valid, 0);
        chk("rst frame_start", frame_start, 0);
        chk("rst fifo_level", fifo_level, 0);
        chk("rst overflow", overflow, 0);
        chk("rst pix_xyc", {pix_x, pix_y, pix_color}, 0);
    endtask

    // Release reset and count the clearing cycles; optionally plot during CLEAR.
    task automatic clear_phase(input bit with_plots);
        int tx[6] = '{7, 7, 5, 2, W, 3};
        int ty[6] = '{7, 7, 0, 3, 1, H};
        logic [2:0] tc[6] = '{3'b001, 3'b110, 3'b101, 3'b011, 3'b111, 3'b111};
        int cnt = 0;
        resetn = 1'b1;
        for (int i = 0; i < 2 * N + 10; i++) begin
            if (!clearing) break;
            cnt++;
            if (with_plots && i < 6) drive_plot(tx[i], ty[i], tc[i], 1'b1);
            else plotPixel = 1'b0;
            @(negedge clk);
        end
        plotPixel = 1'b0;
        chk("clear cycles", cnt, N);
    endtask

    // Compare nfr whole frames against the model, starting at the next frame_start.
    task automatic scan_frames(input int nfr);
        int mism = 0, bad = -1, vcnt = 0, fscnt = 0, t0 = 0, t = 0;
        for (t = 0; t < 2 * N * PD; t++) begin
            @(negedge clk);
            if (pix_valid && frame_start) break;
        end
        if (!(pix_valid && frame_start)) begin
            chk("frame_start timeout", 0, 1);
            return;
        end
        for (int f = 0; f < nfr; f++) begin
            for (int k = 0; k < N; k++) begin
                if (!(f == 0 && k == 0)) begin
                    t = 0;
                    do begin @(negedge clk); t++; end while (!pix_valid && t < 2 * PD);
                    if (!pix_valid) begin
                        chk("pix_valid timeout", 0, 1);
                        return;
                    end
                end
                vcnt++;
                if (frame_start) fscnt++;
                if (k == 0) begin
                    if (f > 0) chk("frame spacing", cyc - t0, N * PD);
                    t0 = cyc;
                end
                if (pix_x !== 8'(k % W) || pix_y !== 8'(k / W) || pix_color !== fb[k]) begin
                    mism++;
                    if (bad < 0) bad = k;
                end
            end
        end
        chk($sformatf("frame pixels (first bad index %0d)", bad), mism, 0);
        chk("pix_valid count", vcnt, nfr * N);
        chk("frame_start count", fscnt, nfr);
    endtask

    initial begin
        int t;
        // Session 1: plots during CLEAR fill the FIFO; out-of-range plots are ignored.
        do_reset();
        clear_phase(1'b1);
        chk("fifo full at run entry", fifo_level, 4);
        chk("no overflow from filtered plots", overflow, 0);
        chk("run entry pix_valid", pix_valid, 0);
        drive_plot(9, 9, 3'b010, 1'b0);    // div==0, no pop: dropped
        @(negedge clk);
        chk("first pix_valid", pix_valid, 1);
        chk("first pix xy", {pix_x, pix_y}, 0);
        chk("first pix color", pix_color, 0);
        chk("first frame_start", frame_start, 1);
        drive_plot(10, 4, 3'b100, 1'b1);   // pop this cycle frees a slot
        @(negedge clk);
        plotPixel = 1'b0;
        chk("level after pop+push", fifo_level, 4);
        chk("overflow after drop", overflow, 1);
        scan_frames(2);
        repeat (300) @(negedge clk);
        chk("overflow sticky", overflow, 1);

        // Session 2: mid-frame reset wipes the picture, then random plots in RUN.
        do_reset();
        clear_phase(1'b0);
        scan_frames(1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive_plot($urandom_range(W + 1, 0), $urandom_range(H, 0), 3'($urandom_range(7, 0)), 1'b1);
            @(negedge clk);
            plotPixel = 1'b0;
            repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        for (t = 0; t < 100 && fifo_level != 0; t++) @(negedge clk);
        chk("fifo drained", fifo_level, 0);
        scan_frames(1);
        chk("overflow after paced plots", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
